uart_core_os: RTL

Single-clock, fully parametrised UART core: data width, parity mode and stop-bit count are set by parameters, and four baud rates are selectable at run time.
- Baud derivation uses a clock-enable tick with 16x oversampling; no derived clocks, so no cross-domain sync blocks are needed.
- The receiver takes a majority vote at mid-bit, supports false-start rejection, and flags parity, framing and overrun errors.
- The block sits between the system bus (valid/ready on both directions) and the serial pins; it replaces the divided-clock UART.

---
 rtl/uart_core_os.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_core_os.sv
// UART core with 16x-oversampled tick, run-time baud select and majority-vote receiver.
// TX starts the cycle after accept and is ready only when idle; RX holds rx_valid until rx_ready and drops frames (overrun) while full.
module uart_core_os #(
  parameter int WIDTH_SIZE  = 8,
  parameter int CLK_FREQ    = 1_843_200,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sel,
  input  logic [WIDTH_SIZE-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic [WIDTH_SIZE-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err
);
  localparam int D0 = CLK_FREQ / (16 * 9600);
  localparam int D1 = CLK_FREQ / (16 * 19200);
  localparam int D2 = CLK_FREQ / (16 * 38400);
  localparam int D3 = CLK_FREQ / (16 * 115200);
  localparam int DIV0 = (D0 > 0) ? D0 : 1;
  localparam int DIV1 = (D1 > 0) ? D1 : 1;
  localparam int DIV2 = (D2 > 0) ? D2 : 1;
  localparam int DIV3 = (D3 > 0) ? D3 : 1;
  localparam logic PAR_EN  = 1'(PARITY_MODE != 0);
  localparam logic PAR_ODD = 1'(PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [15:0] div_m1, bcnt;
  logic [1:0]  sel_q;
  logic        tick;

  always_comb begin
    div_m1 = 16'(DIV0 - 1);
    case (sel)
      2'd1:    div_m1 = 16'(DIV1 - 1);
      2'd2:    div_m1 = 16'(DIV2 - 1);
      2'd3:    div_m1 = 16'(DIV3 - 1);
      default: div_m1 = 16'(DIV0 - 1);
    endcase
  end

  // A sel change suppresses the tick and restarts the count from zero.
  assign tick = (sel == sel_q) && (bcnt == div_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt  <= '0;
      sel_q <= sel;
    end else begin
      sel_q <= sel;
      if (sel != sel_q || tick) bcnt <= '0;
      else                      bcnt <= bcnt + 16'd1;
    end
  end

  state_t                tx_st;
  logic [WIDTH_SIZE-1:0] tx_sh;
  logic                  tx_par;
  logic [4:0]            tx_tcnt, tx_last;
  logic [3:0]            tx_bidx;

  assign tx_last = (tx_st == STOP) ? 5'(16 * STOP_BITS - 1) : 5'd15;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_tcnt  <= '0;
      tx_bidx  <= '0;
    end else if (tx_st == IDLE) begin
      tx <= 1'b1;
      if (tx_valid && tx_ready) begin
        tx_sh    <= tx_data;
        tx_par   <= (^tx_data) ^ PAR_ODD;
        tx       <= 1'b0;
        tx_ready <= 1'b0;
        tx_tcnt  <= '0;
        tx_bidx  <= '0;
        tx_st    <= START;
      end else begin
        tx_ready <= 1'b1;
      end
    end else if (tick) begin
      if (tx_tcnt != tx_last) begin
        tx_tcnt <= tx_tcnt + 5'd1;
      end else begin
        tx_tcnt <= '0;
        case (tx_st)
          START: begin
            tx_st <= DATA;
            tx    <= tx_sh[0];
          end
          DATA: begin
            if (tx_bidx == 4'(WIDTH_SIZE - 1)) begin
              tx_st <= PAR_EN ? PARITY : STOP;
              tx    <= PAR_EN ? tx_par : 1'b1;
            end else begin
              tx_bidx <= tx_bidx + 4'd1;
              tx_sh   <= tx_sh >> 1;
              tx      <= tx_sh[1];
            end
          end
          PARITY: begin
            tx_st <= STOP;
            tx    <= 1'b1;
          end
          default: begin
            tx_st    <= IDLE;
            tx_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  logic                  rx_s1, rs;
  state_t                rx_st;
  logic [3:0]            scnt, rx_bidx;
  logic [1:0]            smp;
  logic                  bitv, rx_par, brk, maj;
  logic [WIDTH_SIZE-1:0] rx_sh;

  assign maj = (smp[0] & smp[1]) | (smp[0] & rs) | (smp[1] & rs);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1       <= 1'b1;
      rs          <= 1'b1;
      rx_st       <= IDLE;
      scnt        <= '0;
      rx_bidx     <= '0;
      smp         <= '0;
      bitv        <= 1'b0;
      rx_par      <= 1'b0;
      brk         <= 1'b0;
      rx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_s1       <= rx;
      rs          <= rx_s1;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tick) begin
        case (rx_st)
          // After a low stop bit (break) the line must go high before a new start is taken.
          IDLE: begin
            if (brk) begin
              brk <= !rs;
            end else if (!rs) begin
              rx_st <= START;
              scnt  <= '0;
            end
          end
          START: begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd7 && rs) begin
              rx_st <= IDLE;
            end else if (scnt == 4'd15) begin
              rx_st   <= DATA;
              rx_bidx <= '0;
            end
          end
          default: begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd7) smp[0] <= rs;
            if (scnt == 4'd8) smp[1] <= rs;
            if (scnt == 4'd9) bitv   <= maj;
            if (rx_st == STOP && scnt == 4'd9) begin
              rx_st <= IDLE;
              brk   <= !maj;
              if (!rx_valid || rx_ready) begin
                rx_valid   <= 1'b1;
                rx_data    <= rx_sh;
                frame_err  <= !maj;
                parity_err <= PAR_EN && (rx_par != ((^rx_sh) ^ PAR_ODD));
              end else begin
                overrun_err <= 1'b1;
              end
            end else if (scnt == 4'd15) begin
              if (rx_st == DATA) begin
                rx_sh <= {bitv, rx_sh[WIDTH_SIZE-1:1]};
                if (rx_bidx == 4'(WIDTH_SIZE - 1)) rx_st <= PAR_EN ? PARITY : STOP;
                else                               rx_bidx <= rx_bidx + 4'd1;
              end else begin
                rx_par <= bitv;
                rx_st  <= STOP;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
